// File: rtl/cla_pkg.sv
// Shared lookahead types for the CLA tree.
// Propagate/generate pairs reused by every level.
package cla_pkg;

    localparam int PG_WIDTH = 2;

    typedef struct packed {
        logic p;
        logic g;
    } pg_pair_t;

endpackage

// File: rtl/pgu_2_if.sv
// Operand/result bundle for the 2-bit PG unit.
// master drives operands, slave returns PG results.
interface pgu_2_if;
    import cla_pkg::*;

    logic                in_valid;
    logic [PG_WIDTH-1:0] a;
    logic [PG_WIDTH-1:0] b;
    logic                out_valid;
    logic [PG_WIDTH-1:0] p_bit;
    logic [PG_WIDTH-1:0] g_bit;
    logic                p;
    logic                g;

    modport master (
        output in_valid, a, b,
        input  out_valid, p_bit, g_bit, p, g
    );

    modport slave (
        input  in_valid, a, b,
        output out_valid, p_bit, g_bit, p, g
    );

endinterface

// File: rtl/pg_cell.sv
// Single-bit propagate/generate cell.
// Purely combinational; p and g are mutually exclusive.
module pg_cell
    import cla_pkg::*;
(
    input  logic     a,
    input  logic     b,
    output pg_pair_t pg
);

    // XOR propagates, AND generates
    always_comb begin
        pg.p = a ^ b;
        pg.g = a & b;
    end

endmodule

// File: rtl/pgu_2.sv
// 2-bit propagate/generate unit with one register stage.
// Feeds the next lookahead level from a clean boundary.
module pgu_2
    import cla_pkg::*;
#(
    parameter int WIDTH = PG_WIDTH
) (
    input  logic    clk,
    input  logic    rst_n,
    pgu_2_if.slave  bus
);

    // group equations below only hold for a 2-bit slice
    if (WIDTH != 2) begin : g_bad_width
        $error("pgu_2: WIDTH must be 2");
    end

    pg_pair_t bit_pg [PG_WIDTH];
    pg_pair_t grp;

    for (genvar i = 0; i < PG_WIDTH; i++) begin : g_cell
        pg_cell u_cell (
            .a  (bus.a[i]),
            .b  (bus.b[i]),
            .pg (bit_pg[i])
        );
    end

    // combine the two bit pairs into the group pair
    always_comb begin
        grp.p = bit_pg[1].p & bit_pg[0].p;
        grp.g = bit_pg[1].g | (bit_pg[1].p & bit_pg[0].g);
    end

    logic                vld_q;
    logic [PG_WIDTH-1:0] p_bit_q;
    logic [PG_WIDTH-1:0] g_bit_q;
    logic                p_q;
    logic                g_q;

    // valid tracks in_valid; data only moves on a valid beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= 1'b0;
            p_bit_q <= '0;
            g_bit_q <= '0;
            p_q     <= 1'b0;
            g_q     <= 1'b0;
        end else begin
            vld_q <= bus.in_valid;
            if (bus.in_valid) begin
                p_bit_q <= {bit_pg[1].p, bit_pg[0].p};
                g_bit_q <= {bit_pg[1].g, bit_pg[0].g};
                p_q     <= grp.p;
                g_q     <= grp.g;
            end
        end
    end

    assign bus.out_valid = vld_q;
    assign bus.p_bit     = p_bit_q;
    assign bus.g_bit     = g_bit_q;
    assign bus.p         = p_q;
    assign bus.g         = g_q;

    // a bit can never both propagate and generate
    a_bit_excl: assert property (
        @(posedge clk) (p_bit_q & g_bit_q) == '0
    );

    // same exclusion at group level
    a_grp_excl: assert property (
        @(posedge clk) !(p_q && g_q)
    );

endmodule

// File: tb/tb_pgu_2.sv
// Scoreboard bench for pgu_2.
// Expected beats queued at drive, compared one edge later.
module tb_pgu_2;
    import cla_pkg::*;

    typedef struct {
        logic       v;
        logic [1:0] pb;
        logic [1:0] gb;
        logic       p;
        logic       g;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    exp_t sb_q[$];
    exp_t hold;

    pgu_2_if bus ();

    pgu_2 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] a,
                                   input logic [1:0] b);
        exp_t e;
        e.v  = 1'b1;
        e.pb = a ^ b;
        e.gb = a & b;
        e.p  = e.pb[1] & e.pb[0];
        e.g  = e.gb[1] | (e.pb[1] & e.gb[0]);
        return e;
    endfunction

    function automatic exp_t zero_exp();
        exp_t e;
        e.v  = 1'b0;
        e.pb = 2'b00;
        e.gb = 2'b00;
        e.p  = 1'b0;
        e.g  = 1'b0;
        return e;
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, ".ov"}, 32'(bus.out_valid), 32'd0);
        chk({tag, ".pb"}, 32'(bus.p_bit), 32'd0);
        chk({tag, ".gb"}, 32'(bus.g_bit), 32'd0);
        chk({tag, ".p"},  32'(bus.p), 32'd0);
        chk({tag, ".g"},  32'(bus.g), 32'd0);
    endtask

    task automatic drive(input logic v,
                         input logic [1:0] a,
                         input logic [1:0] b);
        exp_t e;
        @(negedge clk);
        bus.in_valid = v;
        bus.a = v ? a : 2'bxx;
        bus.b = v ? b : 2'bxx;
        e = v ? model(a, b) : zero_exp();
        e.v = v;
        sb_q.push_back(e);
    endtask

    // pop the beat captured at this edge and compare
    always @(posedge clk) begin
        #1;
        if (rst_n && sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("out_valid", 32'(bus.out_valid), 32'(e.v));
            if (e.v) hold = e;
            chk("p_bit", 32'(bus.p_bit), 32'(hold.pb));
            chk("g_bit", 32'(bus.g_bit), 32'(hold.gb));
            chk("p", 32'(bus.p), 32'(hold.p));
            chk("g", 32'(bus.g), 32'(hold.g));
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout want finish");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        hold    = zero_exp();
        rst_n   = 1'b0;
        bus.in_valid = 1'b1;
        bus.a = 2'b11;
        bus.b = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("rst_hold");

        @(negedge clk);
        rst_n = 1'b1;
        bus.in_valid = 1'b0;

        drive(1'b1, 2'b00, 2'b00);
        drive(1'b1, 2'b00, 2'b11);
        drive(1'b1, 2'b11, 2'b00);
        drive(1'b1, 2'b11, 2'b11);
        drive(1'b1, 2'b01, 2'b11);
        drive(1'b1, 2'b01, 2'b10);

        drive(1'b1, 2'b10, 2'b11);
        drive(1'b0, 2'b10, 2'b11);
        drive(1'b1, 2'b10, 2'b11);
        drive(1'b0, 2'b00, 2'b00);

        for (int i = 0; i < 16; i++) begin
            logic [3:0] ab;
            ab = 4'(i);
            drive(1'b1, ab[3:2], ab[1:0]);
        end
        drive(1'b0, 2'b00, 2'b00);
        @(posedge clk);
        #3;

        rst_n = 1'b0;
        #1;
        chk_zero("rst_async");
        hold = zero_exp();
        @(negedge clk);
        rst_n = 1'b1;

        drive(1'b1, 2'b11, 2'b11);
        #2;
        rst_n = 1'b0;
        sb_q.delete();
        @(posedge clk);
        #2;
        chk_zero("rst_inflight");
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;

        drive(1'b1, 2'b01, 2'b10);
        drive(1'b0, 2'b00, 2'b00);
        @(posedge clk);
        #2;
        chk("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
